// File: rtl/clock_pkg.sv
// Shared timekeeping constants and the hour-of-day type used by the clock chain.
package clock_pkg;

  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned HOURS_HALF    = 12;

  typedef logic [4:0] hour_t;

endpackage

// File: rtl/hour_to_bcd.sv
// Combinational hour-of-day to BCD display digits, 12h or 24h format.
module hour_to_bcd
  import clock_pkg::*;
(
  input  logic [4:0] hour_i,
  input  logic       mode_24_i,
  output logic [1:0] tens_o,
  output logic [3:0] ones_o
);

  hour_t disp;

  always_comb begin
    disp = hour_i;
    if (!mode_24_i) begin
      if (hour_i >= hour_t'(HOURS_HALF)) begin
        disp = hour_i - hour_t'(HOURS_HALF);
      end
      // Midnight and noon both read as 12 on a 12h face.
      if (disp == hour_t'(0)) begin
        disp = hour_t'(HOURS_HALF);
      end
    end

    if (disp >= hour_t'(20)) begin
      tens_o = 2'd2;
      ones_o = 4'(disp - hour_t'(20));
    end else if (disp >= hour_t'(10)) begin
      tens_o = 2'd1;
      ones_o = 4'(disp - hour_t'(10));
    end else begin
      tens_o = 2'd0;
      ones_o = 4'(disp);
    end
  end

endmodule

// File: rtl/counter_hour.sv
// Hour stage of the clock chain: counts minute wraps, manual set, BCD display and day-wrap pulse.
module counter_hour
  import clock_pkg::*;
#(
  parameter int unsigned RESET_HOUR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       zC,
  input  logic       set_en,
  input  logic       set_inc,
  input  logic       mode_24,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic       pm,
  output logic       zH
);

  if (RESET_HOUR >= HOURS_PER_DAY) begin : g_bad_reset_hour
    $error("counter_hour: RESET_HOUR must be in 0..23");
  end

  hour_t hour_q, hour_d, hour_next;
  logic  inc_q;
  logic  zh_q, zh_d;
  logic  inc_rise;
  logic  at_last;

  assign at_last   = (hour_q == hour_t'(HOURS_PER_DAY - 1));
  assign hour_next = at_last ? hour_t'(0) : hour_q + hour_t'(1);
  assign inc_rise  = set_inc & ~inc_q;

  always_comb begin
    hour_d = hour_q;
    zh_d   = 1'b0;
    if (set_en) begin
      // Setting never produces a day carry; zC is dropped while setting.
      if (inc_rise) begin
        hour_d = hour_next;
      end
    end else if (zC) begin
      hour_d = hour_next;
      zh_d   = at_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour_q <= hour_t'(RESET_HOUR);
      inc_q  <= 1'b0;
      zh_q   <= 1'b0;
    end else begin
      hour_q <= hour_d;
      inc_q  <= set_inc;
      zh_q   <= zh_d;
    end
  end

  assign zH = zh_q;
  assign pm = (hour_q >= hour_t'(HOURS_HALF));

  hour_to_bcd u_hour_to_bcd (
    .hour_i    (hour_q),
    .mode_24_i (mode_24),
    .tens_o    (hour_tens),
    .ones_o    (hour_ones)
  );

endmodule

// File: tb/tb_counter_hour.sv
// Directed self-checking bench for counter_hour.
module tb_counter_hour;

  logic       clk;
  logic       reset;
  logic       zC;
  logic       set_en;
  logic       set_inc;
  logic       mode_24;
  logic [1:0] hour_tens;
  logic [3:0] hour_ones;
  logic       pm;
  logic       zH;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-written 12h face for hour-of-day 0..23.
  int face12 [24] = '{12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                      12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};

  counter_hour #(
    .RESET_HOUR (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .zC        (zC),
    .set_en    (set_en),
    .set_inc   (set_inc),
    .mode_24   (mode_24),
    .hour_tens (hour_tens),
    .hour_ones (hour_ones),
    .pm        (pm),
    .zH        (zH)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_zc(input int n);
    for (int i = 0; i < n; i++) begin
      zC = 1'b1;
      @(negedge clk);
      zC = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) begin
      set_inc = 1'b1;
      @(negedge clk);
      set_inc = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    zC      = 1'b0;
    set_en  = 1'b0;
    set_inc = 1'b0;
    mode_24 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({hour_tens, hour_ones, pm, zH} !== {2'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_24h: got %0d%0d pm=%b zH=%b, want 00 pm=0 zH=0",
               hour_tens, hour_ones, pm, zH);
    end
    mode_24 = 1'b0;
    #1;
    n_checks++;
    if ({hour_tens, hour_ones, pm} !== {2'd1, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_12h: got %0d%0d pm=%b, want 12 pm=0", hour_tens, hour_ones, pm);
    end
    mode_24 = 1'b1;
    pulse_zc(3);
    n_checks++;
    if ({hour_tens, hour_ones} !== {2'd0, 4'd3}) begin
      n_fail++;
      $display("FAIL pre_async: got %0d%0d, want 03", hour_tens, hour_ones);
    end
    // Reset lands mid-cycle while a zC pulse is being driven.
    zC = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({hour_tens, hour_ones, pm, zH} !== {2'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got %0d%0d pm=%b zH=%b, want 00 before edge",
               hour_tens, hour_ones, pm, zH);
    end
    @(negedge clk);
    n_checks++;
    if ({hour_tens, hour_ones, zH} !== {2'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got %0d%0d zH=%b, want 00 zH=0",
               hour_tens, hour_ones, zH);
    end
    zC    = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count;
    pulse_zc(1);
    n_checks++;
    if ({hour_tens, hour_ones, zH} !== {2'd0, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL count_first: got %0d%0d zH=%b, want 01 zH=0", hour_tens, hour_ones, zH);
    end
    pulse_zc(10);
    n_checks++;
    if ({hour_tens, hour_ones, pm} !== {2'd1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL count_11: got %0d%0d pm=%b, want 11 pm=0", hour_tens, hour_ones, pm);
    end
    mode_24 = 1'b0;
    #1;
    n_checks++;
    if ({hour_tens, hour_ones, pm} !== {2'd1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL count_11_12h: got %0d%0d pm=%b, want 11 pm=0", hour_tens, hour_ones, pm);
    end
    pulse_zc(1);
    n_checks++;
    if ({hour_tens, hour_ones, pm} !== {2'd1, 4'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL count_12_12h: got %0d%0d pm=%b, want 12 pm=1", hour_tens, hour_ones, pm);
    end
    mode_24 = 1'b1;
    #1;
    n_checks++;
    if ({hour_tens, hour_ones, pm} !== {2'd1, 4'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL count_12_24h: got %0d%0d pm=%b, want 12 pm=1", hour_tens, hour_ones, pm);
    end
    // Back-to-back zC: both pulses count.
    zC = 1'b1;
    repeat (2) @(negedge clk);
    zC = 1'b0;
    n_checks++;
    if ({hour_tens, hour_ones} !== {2'd1, 4'd4}) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d%0d, want 14", hour_tens, hour_ones);
    end
    pulse_zc(9);
    n_checks++;
    if ({hour_tens, hour_ones, pm, zH} !== {2'd2, 4'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL count_23: got %0d%0d pm=%b zH=%b, want 23 pm=1 zH=0",
               hour_tens, hour_ones, pm, zH);
    end
    zC = 1'b1;
    @(negedge clk);
    zC = 1'b0;
    n_checks++;
    if ({hour_tens, hour_ones, pm, zH} !== {2'd0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL day_wrap: got %0d%0d pm=%b zH=%b, want 00 pm=0 zH=1",
               hour_tens, hour_ones, pm, zH);
    end
    @(negedge clk);
    n_checks++;
    if (zH !== 1'b0) begin
      n_fail++;
      $display("FAIL zh_width: got zH=%b, want 0 one cycle after wrap", zH);
    end
    mode_24 = 1'b0;
    #1;
    n_checks++;
    if ({hour_tens, hour_ones, pm} !== {2'd1, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_12h: got %0d%0d pm=%b, want 12 pm=0", hour_tens, hour_ones, pm);
    end
    mode_24 = 1'b1;
  endtask

  task automatic test_set;
    logic saw_zh;
    saw_zh = 1'b0;
    set_en = 1'b1;
    @(negedge clk);
    pulse_zc(5);
    n_checks++;
    if ({hour_tens, hour_ones} !== {2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL set_ignores_zc: got %0d%0d, want 00", hour_tens, hour_ones);
    end
    set_inc = 1'b1;
    repeat (10) begin
      @(negedge clk);
      saw_zh |= zH;
    end
    set_inc = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({hour_tens, hour_ones} !== {2'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL held_button: got %0d%0d, want 01", hour_tens, hour_ones);
    end
    for (int i = 0; i < 3; i++) begin
      set_inc = 1'b1;
      @(negedge clk);
      saw_zh |= zH;
      set_inc = 1'b0;
      @(negedge clk);
      saw_zh |= zH;
    end
    n_checks++;
    if ({hour_tens, hour_ones} !== {2'd0, 4'd4}) begin
      n_fail++;
      $display("FAIL three_presses: got %0d%0d, want 04", hour_tens, hour_ones);
    end
    n_checks++;
    if (saw_zh !== 1'b0) begin
      n_fail++;
      $display("FAIL set_no_zh: got zH seen=%b, want 0", saw_zh);
    end
  endtask

  task automatic test_set_wrap;
    press(19);
    n_checks++;
    if ({hour_tens, hour_ones} !== {2'd2, 4'd3}) begin
      n_fail++;
      $display("FAIL set_to_23: got %0d%0d, want 23", hour_tens, hour_ones);
    end
    set_inc = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({hour_tens, hour_ones, zH} !== {2'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL set_wrap: got %0d%0d zH=%b, want 00 zH=0", hour_tens, hour_ones, zH);
    end
    set_inc = 1'b0;
    @(negedge clk);
    set_en  = 1'b0;
    set_inc = 1'b1;
    repeat (2) @(negedge clk);
    set_en = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hour_tens, hour_ones} !== {2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL held_on_entry: got %0d%0d, want 00", hour_tens, hour_ones);
    end
    set_inc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep;
    int v;
    logic [1:0] et;
    logic [3:0] eo;
    for (int h = 0; h < 24; h++) begin
      mode_24 = 1'b1;
      #1;
      et = 2'(h / 10);
      eo = 4'(h % 10);
      n_checks++;
      if ({hour_tens, hour_ones, pm} !== {et, eo, (h >= 12)}) begin
        n_fail++;
        $display("FAIL sweep24 h=%0d: got %0d%0d pm=%b, want %0d%0d pm=%b",
                 h, hour_tens, hour_ones, pm, et, eo, (h >= 12));
      end
      mode_24 = 1'b0;
      #1;
      v  = face12[h];
      et = 2'(v / 10);
      eo = 4'(v % 10);
      n_checks++;
      if ({hour_tens, hour_ones, pm} !== {et, eo, (h >= 12)}) begin
        n_fail++;
        $display("FAIL sweep12 h=%0d: got %0d%0d pm=%b, want %0d%0d pm=%b",
                 h, hour_tens, hour_ones, pm, et, eo, (h >= 12));
      end
      press(1);
    end
    mode_24 = 1'b1;
    set_en  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_set();
    test_set_wrap();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
